// File: rtl/video_pkg.sv
// Shared video definitions: RGB565 field positions, packer FSM encoding and
// the 24-bit to RGB565 conversion helper.
package video_pkg;

    localparam int PIX565_W = 16;

    // Bit positions of the retained MSBs inside {R[23:16],G[15:8],B[7:0]}
    localparam int R_HI = 23;
    localparam int R_LO = 19;
    localparam int G_HI = 15;
    localparam int G_LO = 10;
    localparam int B_HI = 7;
    localparam int B_LO = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic [PIX565_W-1:0] to_rgb565(input logic [23:0] rgb);
        return {rgb[R_HI:R_LO], rgb[G_HI:G_LO], rgb[B_HI:B_LO]};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head word is visible on
// o_data whenever o_empty is low; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 256,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_rd    = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_rd);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap modulo DEPTH; occupancy tracks accepted pushes and pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/crop_stream_packer.sv
// Packs the cropped pixel stream into RGB565 pairs, buffers the words and
// emits them as fixed-length bursts; a frame boundary flushes the remainder.
module crop_stream_packer
    import video_pkg::*;
#(
    parameter int FIFO_DEPTH = 256,
    parameter int BURST_LEN  = 16,
    parameter int CNT_W      = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [23:0] rgb_i,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        m_sof,
    output logic        ovf_o
);
    localparam int BW = $clog2(BURST_LEN);

    logic                r_vs_d;
    logic                r_rise_p1;
    logic                r_armed;
    logic                r_sof_pend;
    logic                r_flush_req;
    logic                r_ovf;
    logic                r_half_vld;
    logic [PIX565_W-1:0] r_half;
    logic                r_push_vld_p1;
    logic [32:0]         r_push_word_p1;

    logic                w_vs_rise;
    logic                w_px_acc;
    logic [PIX565_W-1:0] w_px565;

    logic [32:0]         w_fifo_dout;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BW-1:0]       r_beat;
    logic [BW-1:0]       w_beat_idx;
    logic [CNT_W-1:0]    r_fl_cnt;
    logic                w_load;
    logic                w_last_nxt;
    logic                w_fl_snap;
    logic                w_flush_clr;

    logic [31:0]         r_m_data;
    logic                r_m_valid;
    logic                r_m_last;
    logic                r_m_sof;

    assign w_vs_rise = vs_i & ~r_vs_d;
    assign w_px_acc  = r_armed & de_i & ~vs_i;
    assign w_px565   = to_rgb565(rgb_i);

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign m_sof   = r_m_sof;
    assign ovf_o   = r_ovf;

    // Input control: arming, pair tracking, sof tagging, flush request, overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d        <= 1'b0;
            r_rise_p1     <= 1'b0;
            r_armed       <= 1'b0;
            r_sof_pend    <= 1'b0;
            r_half_vld    <= 1'b0;
            r_push_vld_p1 <= 1'b0;
            r_flush_req   <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_vs_d        <= vs_i;
            r_rise_p1     <= w_vs_rise;
            r_push_vld_p1 <= 1'b0;
            if (w_vs_rise) begin
                r_armed    <= 1'b1;
                r_sof_pend <= 1'b1;
                if (r_half_vld) begin
                    r_push_vld_p1 <= 1'b1;
                    r_half_vld    <= 1'b0;
                end
            end else if (w_px_acc) begin
                r_half_vld <= ~r_half_vld;
                if (r_half_vld) begin
                    r_push_vld_p1 <= 1'b1;
                    r_sof_pend    <= 1'b0;
                end
            end
            // Raised one cycle after the edge so a padded word is already counted
            if (r_rise_p1)        r_flush_req <= 1'b1;
            else if (w_flush_clr) r_flush_req <= 1'b0;
            if (r_push_vld_p1 && w_full && !w_load) r_ovf <= 1'b1;
        end
    end

    // Pixel datapath: even-pixel half register and the word staged for push
    always_ff @(posedge clk) begin
        if (w_px_acc && !r_half_vld) r_half <= w_px565;
        if (w_vs_rise)     r_push_word_p1 <= {r_sof_pend, 16'h0000, r_half};
        else if (w_px_acc) r_push_word_p1 <= {r_sof_pend, w_px565, r_half};
    end

    sync_fifo_fwft #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push_vld_p1),
        .i_pop   (w_load),
        .i_data  (r_push_word_p1),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Burst FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, output-register load and flush bookkeeping
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fl_snap   = 1'b0;
        w_flush_clr = 1'b0;
        w_beat_idx  = r_m_valid ? (r_beat + BW'(1)) : '0;
        w_last_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_count >= CNT_W'(BURST_LEN)) begin
                    w_state_nxt = BURST;
                end else if (r_flush_req) begin
                    w_flush_clr = 1'b1;
                    if (w_count != '0) begin
                        w_state_nxt = FLUSH;
                        w_fl_snap   = 1'b1;
                    end
                end
            end
            BURST, FLUSH: begin
                // Refill the output register when it is empty or its non-final beat leaves
                w_load = (~r_m_valid | (m_ready & ~r_m_last)) & ~w_empty;
                if (r_state == BURST) w_last_nxt = (w_beat_idx == BW'(BURST_LEN - 1));
                else                  w_last_nxt = (CNT_W'(w_beat_idx) == r_fl_cnt - CNT_W'(1));
                if (r_m_valid && m_ready && r_m_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered master port, beat index and flush length snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_sof   <= 1'b0;
            r_beat    <= '0;
            r_fl_cnt  <= '0;
        end else begin
            if (w_fl_snap) r_fl_cnt <= w_count;
            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_fifo_dout[31:0];
                r_m_sof   <= w_fifo_dout[32];
                r_m_last  <= w_last_nxt;
                r_beat    <= w_beat_idx;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
                r_m_sof   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crop_stream_packer.sv
// Randomized bench for crop_stream_packer: a frame-level reference model
// derives the expected word stream, burst framing and sof tags from the pixels.
module tb_crop_stream_packer;
    localparam int FIFO_DEPTH = 256;
    localparam int BURST_LEN  = 16;
    localparam int CNT_W      = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs_i = 1'b0;
    logic        de_i = 1'b0;
    logic [23:0] rgb_i = '0;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_sof;
    logic        ovf_o;

    crop_stream_packer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BURST_LEN  (BURST_LEN),
        .CNT_W      (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vs_i    (vs_i),
        .de_i    (de_i),
        .rgb_i   (rgb_i),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_sof   (m_sof),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          rand_ready = 1'b0;
    logic [15:0] px_q[$];
    logic [33:0] exp_q[$];
    logic [33:0] obs_q[$];
    logic [33:0] prev_beat = '0;
    bit          prev_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] ref565(input logic [23:0] c);
        int r, g, b;
        r = ((c >> 16) & 255) / 8;
        g = ((c >> 8) & 255) / 4;
        b = (c & 255) / 8;
        return 16'(r * 2048 + g * 32 + b);
    endfunction

    // Frame model: pixel pairs, zero-padded odd tail, sof on word 0,
    // last at every BURST_LEN-th word and on the frame's final word.
    task automatic build_expected();
        int n, nw;
        logic [15:0] lo, hi;
        n  = px_q.size();
        nw = (n + 1) / 2;
        exp_q.delete();
        for (int i = 0; i < nw; i++) begin
            lo = px_q[2*i];
            hi = (2*i + 1 < n) ? px_q[2*i+1] : 16'h0000;
            exp_q.push_back({((i + 1) % BURST_LEN == 0) || (i == nw - 1), i == 0, hi, lo});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic vs_pulse();
        de_i = 1'b0;
        vs_i = 1'b1;
        repeat (3) tick();
        vs_i = 1'b0;
        tick();
    endtask

    task automatic send_px(input int n, input bit dense, input bit fixed, input logic [23:0] col, input bit record);
        for (int k = 0; k < n; k++) begin
            if (!dense) begin
                while ($urandom_range(0, 2) == 0) begin
                    de_i = 1'b0;
                    tick();
                end
            end
            rgb_i = fixed ? col : 24'($urandom);
            de_i  = 1'b1;
            if (record) px_q.push_back(ref565(rgb_i));
            tick();
        end
        de_i = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int cyc;
        cyc = 0;
        while (obs_q.size() < n && cyc < 3000) begin
            tick();
            cyc++;
        end
        repeat (40) tick();
    endtask

    task automatic compare_exp(input string tag, input int limit);
        int m;
        m = (limit < exp_q.size()) ? limit : exp_q.size();
        if (obs_q.size() < m) m = obs_q.size();
        for (int i = 0; i < m; i++)
            check($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
    endtask

    task automatic clear_all();
        px_q.delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    // Beat monitor and stall-stability checks, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(m_valid), 64'(1));
                check("stall_hold", 64'({m_last, m_sof, m_data}), 64'(prev_beat));
            end
            if (m_valid && m_ready) obs_q.push_back({m_last, m_sof, m_data});
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_sof, m_data};
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nfr;
        logic [33:0] w;

        // Reset state
        repeat (3) tick();
        check("rst_valid", 64'(m_valid), 0);
        check("rst_data", 64'(m_data), 0);
        check("rst_last", 64'(m_last), 0);
        check("rst_sof", 64'(m_sof), 0);
        check("rst_ovf", 64'(ovf_o), 0);
        rst_n = 1'b1;
        tick();

        // Unarmed input is ignored
        m_ready = 1'b1;
        for (int l = 0; l < 4; l++) begin
            send_px(32, 1'b1, 1'b0, 24'h0, 1'b0);
            repeat (4) tick();
        end
        repeat (50) tick();
        check("t1_no_beats", 64'(obs_q.size()), 0);
        check("t1_fifo_count", 64'(dut.u_fifo.o_count), 0);

        // One regular burst of a fixed colour
        clear_all();
        vs_pulse();
        send_px(32, 1'b1, 1'b1, 24'hFF8040, 1'b1);
        build_expected();
        wait_beats(16);
        check("t2_beats", 64'(obs_q.size()), 16);
        compare_exp("t2", 16);
        if (obs_q.size() > 15) begin
            w = obs_q[0];
            check("t2_word", 64'(w[31:0]), 64'h0000_0000_FC08_FC08);
            check("t2_sof0", 64'(w[32]), 1);
            w = obs_q[15];
            check("t2_last15", 64'(w[33]), 1);
        end

        // Burst followed by a 2-beat flush with padded tail
        clear_all();
        vs_pulse();
        send_px(35, 1'b0, 1'b0, 24'h0, 1'b1);
        repeat (3) tick();
        vs_pulse();
        build_expected();
        wait_beats(18);
        check("t3_beats", 64'(obs_q.size()), 18);
        compare_exp("t3", 18);
        if (obs_q.size() > 17) begin
            w = obs_q[17];
            check("t3_tail_word", 64'(w[31:0]), 64'({16'h0000, px_q[34]}));
            check("t3_tail_last", 64'(w[33]), 1);
        end

        // Random backpressure over several frames of random length
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            clear_all();
            vs_pulse();
            nfr = $urandom_range(20, 120);
            send_px(nfr, 1'b0, 1'b0, 24'h0, 1'b1);
            repeat (3) tick();
            vs_pulse();
            build_expected();
            wait_beats(exp_q.size());
            check($sformatf("t4_f%0d_beats", f), 64'(obs_q.size()), 64'(exp_q.size()));
            compare_exp($sformatf("t4_f%0d", f), exp_q.size());
        end
        rand_ready = 1'b0;

        // Overflow with the sink stalled
        clear_all();
        m_ready = 1'b0;
        vs_pulse();
        send_px(480, 1'b1, 1'b0, 24'h0, 1'b1);
        repeat (3) tick();
        check("t5_no_ovf_yet", 64'(ovf_o), 0);
        send_px(120, 1'b1, 1'b0, 24'h0, 1'b1);
        repeat (3) tick();
        check("t5_ovf_set", 64'(ovf_o), 1);
        m_ready = 1'b1;
        vs_pulse();
        build_expected();
        wait_beats(FIFO_DEPTH);
        check("t5_drain_cnt", 64'(obs_q.size() >= FIFO_DEPTH && obs_q.size() <= FIFO_DEPTH + 1), 1);
        compare_exp("t5", FIFO_DEPTH);
        check("t5_ovf_sticky", 64'(ovf_o), 1);

        // Asynchronous reset mid-burst, then re-arm
        clear_all();
        vs_pulse();
        send_px(40, 1'b1, 1'b0, 24'h0, 1'b1);
        begin
            int cyc;
            cyc = 0;
            while (obs_q.size() < 7 && cyc < 500) begin
                tick();
                cyc++;
            end
        end
        check("t6_midburst", 64'(m_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(m_valid), 0);
        check("t6_rst_data", 64'(m_data), 0);
        check("t6_rst_last", 64'(m_last), 0);
        check("t6_rst_sof", 64'(m_sof), 0);
        check("t6_rst_ovf", 64'(ovf_o), 0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_all();
        repeat (30) tick();
        check("t6_quiet", 64'(obs_q.size()), 0);
        vs_pulse();
        send_px(32, 1'b0, 1'b0, 24'h0, 1'b1);
        repeat (3) tick();
        vs_pulse();
        build_expected();
        wait_beats(16);
        check("t6_beats", 64'(obs_q.size()), 16);
        compare_exp("t6", 16);
        if (obs_q.size() > 0) begin
            w = obs_q[0];
            check("t6_sof", 64'(w[32]), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
